cam_stream_gen: RTL and testbench

//  Synthetic OV7670-style camera source: drives VSYNC/HREF/8-bit DATA, 2 bytes/pixel RGB565,
//  one byte per CLK cycle. Transmit side of the camera capture interface; feeds CONTROL_UNIT
//  in place of the real camera for bring-up of the capture -> M9K -> VGA/IMAGE_PROCESSOR path.

---
 rtl/cam_stream_gen.sv | 185 ++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style camera source: VSYNC/HREF/8-bit DATA, RGB565 as two bytes per pixel.
// Define CAM_GEN_CRC_EN to add a per-frame CRC-16-CCITT of the active bytes on FRAME_CRC.
module cam_stream_gen #(
  parameter int H_ACTIVE  = 176,
  parameter int V_ACTIVE  = 144,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  parameter int BOX_HALF  = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [1:0]  PATTERN,
  input  logic [15:0] COLOR,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_CRC
);

  localparam int L        = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_A    = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int MAX_B    = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int LINE_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(L + 1);
  localparam int LW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(L - 1);
  localparam logic [CW-1:0] ACT_BYTES = CW'(2 * H_ACTIVE);
  localparam logic [15:0]   BAR_W     = 16'(H_ACTIVE / 8);
  localparam logic [15:0]   H_MID     = 16'(H_ACTIVE / 2);
  localparam logic [15:0]   V_MID     = 16'(V_ACTIVE / 2);
  localparam logic [15:0]   BOX       = 16'(BOX_HALF);

  typedef enum logic [2:0] {IDLE, VS, VBP, ACTIVE, VFP} state_t;

  state_t        state, nstate;
  logic [CW-1:0] cyc, ncyc;
  logic [LW-1:0] line, nline, line_last;
  logic [1:0]    pat_q;
  logic [15:0]   col_q;
  logic          last_cyc, last_line, frame_end, vs_entry;
  logic [15:0]   xw, yw, dx, dy, pix;
  logic [2:0]    bar;
  logic          next_href;
  logic [7:0]    next_data;

  always_comb begin
    case (state)
      VS:      line_last = LW'(VS_LINES - 1);
      VBP:     line_last = LW'(VBP_LINES - 1);
      ACTIVE:  line_last = LW'(V_ACTIVE - 1);
      VFP:     line_last = LW'(VFP_LINES - 1);
      default: line_last = '0;
    endcase
  end

  assign last_cyc  = (cyc == CYC_LAST);
  assign last_line = (line == line_last);
  assign frame_end = (state == VFP) && last_cyc && last_line;

  // Transition function; all outputs are registered from the next-cycle position
  // so that they line up with the state they belong to.
  always_comb begin
    nstate = state;
    ncyc   = cyc;
    nline  = line;
    if (state == IDLE) begin
      if (EN) begin
        nstate = VS;
        ncyc   = '0;
        nline  = '0;
      end
    end else if (last_cyc) begin
      ncyc = '0;
      if (last_line) begin
        nline = '0;
        case (state)
          VS:      nstate = VBP;
          VBP:     nstate = ACTIVE;
          ACTIVE:  nstate = VFP;
          VFP:     nstate = EN ? VS : IDLE;
          default: nstate = IDLE;
        endcase
      end else begin
        nline = line + 1'b1;
      end
    end else begin
      ncyc = cyc + 1'b1;
    end
  end

  assign vs_entry = (nstate == VS) && (state != VS);

  always_comb begin
    xw  = 16'(ncyc >> 1);
    yw  = 16'(nline);
    bar = 3'(xw / BAR_W);
    dx  = (xw >= H_MID) ? (xw - H_MID) : (H_MID - xw);
    dy  = (yw >= V_MID) ? (yw - V_MID) : (V_MID - yw);
    case (pat_q)
      2'd0: pix = col_q;
      2'd1: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = (dx < BOX && dy < BOX) ? 16'hF800 : 16'hFFFF;
      default: pix = {xw[7:3], yw[7:2], 5'b0};
    endcase
    next_href = (nstate == ACTIVE) && (ncyc < ACT_BYTES);
    next_data = next_href ? (ncyc[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cyc        <= '0;
      line       <= '0;
      pat_q      <= '0;
      col_q      <= '0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      DATA       <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      state <= nstate;
      cyc   <= ncyc;
      line  <= nline;
      if (vs_entry) begin
        pat_q <= PATTERN;
        col_q <= COLOR;
      end
      VSYNC      <= (nstate == VS);
      HREF       <= next_href;
      DATA       <= next_data;
      FRAME_DONE <= frame_end;
    end
  end

`ifdef CAM_GEN_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  s;
    r = c;
    s = d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r[15] ^ s[7]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      s = {s[6:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc;

  // The running CRC consumes the byte currently on DATA; the snapshot at frame end
  // takes the pre-reinit value when the next frame starts on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      crc       <= 16'hFFFF;
      FRAME_CRC <= '0;
    end else begin
      if (vs_entry)
        crc <= 16'hFFFF;
      else if (HREF)
        crc <= crc_step(crc, DATA);
      if (frame_end)
        FRAME_CRC <= crc;
    end
  end
`else
  assign FRAME_CRC = '0;
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen using a reduced frame geometry (L=36, frame=432 cycles).
module tb_cam_stream_gen;

  localparam int HA = 16, VA = 8, HB = 4, VSL = 1, VBPL = 2, VFPL = 1, BH = 4;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [1:0]  pattern;
  logic [15:0] color;
  logic        vsync, href, frame_done;
  logic [7:0]  data;
  logic [15:0] frame_crc;

  int checks = 0;
  int errors = 0;

  int cap_vs, cap_first, cap_done, cap_lines, cap_bytes, cap_lownz, cap_badlen;
  logic [15:0] cap_crc;
  logic [7:0]  fb [0:7][0:31];

  cam_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VS_LINES(VSL),
    .VBP_LINES(VBPL), .VFP_LINES(VFPL), .BOX_HALF(BH)
  ) dut (
    .CLK(clk), .RESET(reset), .EN(en), .PATTERN(pattern), .COLOR(color),
    .VSYNC(vsync), .HREF(href), .DATA(data), .FRAME_DONE(frame_done), .FRAME_CRC(frame_crc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_pix(input logic [1:0] p, input logic [15:0] c,
                                          input int x, input int y);
    logic [7:0] xv, yv;
    int dx, dy;
    xv = 8'(x);
    yv = 8'(y);
    dx = (x >= HA / 2) ? x - HA / 2 : HA / 2 - x;
    dy = (y >= VA / 2) ? y - VA / 2 : VA / 2 - y;
    case (p)
      2'd0: return c;
      2'd1: begin
        case (x / (HA / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd2: return (dx < BH && dy < BH) ? 16'hF800 : 16'hFFFF;
      default: return {xv[7:3], yv[7:2], 5'b0};
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input logic [1:0] p, input logic [15:0] c,
                                          input int y, input int k);
    logic [15:0] px;
    px = exp_pix(p, c, k / 2, y);
    return (k % 2 == 1) ? px[7:0] : px[15:8];
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  s;
    r = c;
    s = d;
    for (int i = 0; i < 8; i++) begin
      r = (r[15] ^ s[7]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      s = {s[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_crc(input logic [1:0] p, input logic [15:0] c);
`ifdef CAM_GEN_CRC_EN
    logic [15:0] r;
    r = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int k = 0; k < 2 * HA; k++)
        r = crc_byte(r, exp_byte(p, c, y, k));
    return r;
`else
    return crc_byte(16'h0000, {6'b0, p}) & 16'h0000 & c;
`endif
  endfunction

  function automatic int count_bad(input logic [1:0] p, input logic [15:0] c);
    int n;
    n = 0;
    for (int y = 0; y < VA; y++)
      for (int k = 0; k < 2 * HA; k++)
        if (fb[y][k] !== exp_byte(p, c, y, k)) n++;
    return n;
  endfunction

  // Records one frame starting at the VSYNC rise; inputs for the next frame are
  // applied right after the rise, i.e. mid-frame.
  task automatic capture(input logic [1:0] next_pat, input logic [15:0] next_col,
                         input bit drop_en);
    int t, li, bi;
    bit ph, fin;
    cap_vs = 0; cap_first = -1; cap_done = -1; cap_lines = 0;
    cap_bytes = 0; cap_lownz = 0; cap_badlen = 0; cap_crc = 16'hxxxx;
    for (int y = 0; y < 8; y++)
      for (int k = 0; k < 32; k++)
        fb[y][k] = 8'hxx;
    t = 0;
    while (vsync !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    if (vsync !== 1'b1) return;
    pattern = next_pat;
    color   = next_col;
    t = 0; li = 0; bi = 0; ph = 0; fin = 0;
    while (!fin) begin
      if (t > 0 && frame_done === 1'b1) begin
        cap_done = t;
        cap_crc  = frame_crc;
        fin      = 1;
      end else if (t >= 2000) begin
        fin = 1;
      end else begin
        if (vsync === 1'b1) cap_vs++;
        if (href === 1'b1) begin
          if (cap_first < 0) begin
            cap_first = t;
            if (drop_en) en = 1'b0;
          end
          if (li < 8 && bi < 32) fb[li][bi] = data;
          bi++;
          cap_bytes++;
        end else begin
          if (data !== 8'h00) cap_lownz++;
          if (ph) begin
            if (bi != 2 * HA) cap_badlen++;
            li++;
            bi = 0;
          end
        end
        ph = (href === 1'b1);
        tick();
        t++;
      end
    end
    cap_lines = li;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; pattern = 2'd0; color = 16'hF800;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({vsync, href, data, frame_done} !== 11'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got vs=%b href=%b data=%h done=%b required all 0",
                 i, vsync, href, data, frame_done);
      end
    end
    checks++;
    if (frame_crc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_crc: got %h required 0000", frame_crc);
    end
  endtask

  task automatic test_timing_solid();
    int nb;
    reset = 1'b0;
    tick();
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL first_vsync: got %b required 1", vsync);
    end
    capture(2'd1, 16'hF800, 0);
    checks++;
    if (cap_vs !== 36) begin
      errors++; $display("FAIL vsync_len: got %0d required 36", cap_vs);
    end
    checks++;
    if (cap_first !== 108) begin
      errors++; $display("FAIL first_href: got %0d required 108", cap_first);
    end
    checks++;
    if (cap_lines !== 8 || cap_badlen !== 0) begin
      errors++; $display("FAIL href_lines: got %0d lines %0d bad lengths required 8 lines 0 bad",
                         cap_lines, cap_badlen);
    end
    checks++;
    if (cap_bytes !== 256) begin
      errors++; $display("FAIL href_bytes: got %0d required 256", cap_bytes);
    end
    checks++;
    if (cap_lownz !== 0) begin
      errors++; $display("FAIL data_blank: got %0d nonzero blank bytes required 0", cap_lownz);
    end
    checks++;
    if (cap_done !== 432) begin
      errors++; $display("FAIL frame_period: got %0d required 432", cap_done);
    end
    nb = count_bad(2'd0, 16'hF800);
    checks++;
    if (nb !== 0 || {fb[0][0], fb[0][1], fb[7][30], fb[7][31]} !== 32'hF800_F800) begin
      errors++; $display("FAIL solid_data: got %0d bad bytes, first pair %h%h required 0 bad, F800",
                         nb, fb[0][0], fb[0][1]);
    end
    checks++;
    if (cap_crc !== exp_crc(2'd0, 16'hF800)) begin
      errors++; $display("FAIL solid_crc: got %h required %h", cap_crc, exp_crc(2'd0, 16'hF800));
    end
  endtask

  task automatic test_bars();
    int nb;
    capture(2'd2, 16'hF800, 0);
    nb = count_bad(2'd1, 16'h0000);
    checks++;
    if (cap_done !== 432 || nb !== 0) begin
      errors++; $display("FAIL bars_frame: got period %0d, %0d bad bytes required 432, 0",
                         cap_done, nb);
    end
    checks++;
    if ({fb[0][0], fb[0][3], fb[0][4], fb[0][5], fb[0][8], fb[2][9], fb[3][20], fb[3][21],
         fb[7][28], fb[7][31]} !== 80'hFF_FF_FF_E0_07_FF_F8_00_00_00) begin
      errors++; $display("FAIL bars_spots: got %h %h %h %h %h %h %h %h %h %h required FF FF FF E0 07 FF F8 00 00 00",
                         fb[0][0], fb[0][3], fb[0][4], fb[0][5], fb[0][8], fb[2][9],
                         fb[3][20], fb[3][21], fb[7][28], fb[7][31]);
    end
    checks++;
    if (cap_crc !== exp_crc(2'd1, 16'h0000)) begin
      errors++; $display("FAIL bars_crc: got %h required %h", cap_crc, exp_crc(2'd1, 16'h0000));
    end
  endtask

  task automatic test_box();
    int nb;
    capture(2'd3, 16'hF800, 0);
    nb = count_bad(2'd2, 16'h0000);
    checks++;
    if (cap_done !== 432 || nb !== 0) begin
      errors++; $display("FAIL box_frame: got period %0d, %0d bad bytes required 432, 0",
                         cap_done, nb);
    end
    checks++;
    if ({fb[4][8], fb[4][9], fb[4][10], fb[4][11]} !== 32'hFFFF_F800) begin
      errors++; $display("FAIL box_left_edge: got %h%h %h%h required FFFF F800",
                         fb[4][8], fb[4][9], fb[4][10], fb[4][11]);
    end
    checks++;
    if ({fb[4][22], fb[4][23], fb[4][24], fb[4][25]} !== 32'hF800_FFFF) begin
      errors++; $display("FAIL box_right_edge: got %h%h %h%h required F800 FFFF",
                         fb[4][22], fb[4][23], fb[4][24], fb[4][25]);
    end
    checks++;
    if ({fb[0][10], fb[0][11], fb[1][10], fb[1][11]} !== 32'hFFFF_F800) begin
      errors++; $display("FAIL box_top_edge: got %h%h %h%h required FFFF F800",
                         fb[0][10], fb[0][11], fb[1][10], fb[1][11]);
    end
  endtask

  task automatic test_gradient();
    int nb;
    capture(2'd0, 16'h07E0, 0);
    nb = count_bad(2'd3, 16'h0000);
    checks++;
    if (cap_done !== 432 || nb !== 0) begin
      errors++; $display("FAIL gradient_frame: got period %0d, %0d bad bytes required 432, 0",
                         cap_done, nb);
    end
    checks++;
    if ({fb[4][16], fb[4][17], fb[3][16], fb[3][17], fb[7][2], fb[7][3], fb[0][0], fb[0][1]}
        !== 64'h0820_0800_0020_0000) begin
      errors++; $display("FAIL gradient_spots: got %h%h %h%h %h%h %h%h required 0820 0800 0020 0000",
                         fb[4][16], fb[4][17], fb[3][16], fb[3][17], fb[7][2], fb[7][3],
                         fb[0][0], fb[0][1]);
    end
    checks++;
    if (cap_crc !== exp_crc(2'd3, 16'h0000)) begin
      errors++; $display("FAIL gradient_crc: got %h required %h", cap_crc, exp_crc(2'd3, 16'h0000));
    end
  endtask

  task automatic test_en_low();
    int nb, stray;
    capture(2'd0, 16'h07E0, 1);
    nb = count_bad(2'd0, 16'h07E0);
    checks++;
    if (cap_done !== 432 || nb !== 0) begin
      errors++; $display("FAIL en_low_frame: got period %0d, %0d bad bytes required 432, 0",
                         cap_done, nb);
    end
    checks++;
    if (cap_crc !== exp_crc(2'd0, 16'h07E0)) begin
      errors++; $display("FAIL en_low_crc: got %h required %h", cap_crc, exp_crc(2'd0, 16'h07E0));
    end
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      if (vsync !== 1'b0 || href !== 1'b0 || (i > 0 && frame_done !== 1'b0)) stray++;
      tick();
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL en_low_idle: got %0d active cycles after frame required 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    pattern = 2'd3;
    en = 1'b1;
    tick();
    checks++;
    if (vsync !== 1'b1) begin
      errors++; $display("FAIL restart_vsync: got %b required 1", vsync);
    end
    t = 0;
    while (href !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    repeat (5) tick();
    checks++;
    if (href !== 1'b1) begin
      errors++; $display("FAIL mid_line_reach: got href=%b required 1", href);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({vsync, href, data, frame_done, frame_crc} !== 27'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got vs=%b href=%b data=%h done=%b crc=%h required all 0",
                         vsync, href, data, frame_done, frame_crc);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({vsync, href, frame_done} !== 3'b100) begin
      errors++; $display("FAIL mid_reset_restart: got vs=%b href=%b done=%b required 1 0 0",
                         vsync, href, frame_done);
    end
    capture(2'd3, 16'h07E0, 0);
    checks++;
    if (cap_done !== 432 || count_bad(2'd3, 16'h0000) !== 0 || cap_first !== 108) begin
      errors++; $display("FAIL mid_reset_frame: got period %0d first href %0d bad %0d required 432 108 0",
                         cap_done, cap_first, count_bad(2'd3, 16'h0000));
    end
    checks++;
    if (cap_crc !== exp_crc(2'd3, 16'h0000)) begin
      errors++; $display("FAIL mid_reset_crc: got %h required %h", cap_crc, exp_crc(2'd3, 16'h0000));
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; pattern = 2'd0; color = 16'h0000;
    test_reset();
    test_timing_solid();
    test_bars();
    test_box();
    test_gradient();
    test_en_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
